// File: rtl/jtag_scan_sequencer_if.sv
// Command and TAP-side signal bundle for the JTAG scan sequencer.
// The sequencer connects through the slave modport; the command logic and TAP use master.
interface jtag_scan_sequencer_if #(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned LEN_W   = 6
);
  logic               start;
  logic               ir_sel;
  logic [LEN_W-1:0]   len;
  logic [MAX_LEN-1:0] tdi_data;
  logic [MAX_LEN-1:0] tdo_data;
  logic               busy;
  logic               done;
  logic               err;
  logic               TMS;
  logic               TDI;
  logic               TDO;
  logic [3:0]         tap_state;

  modport master (
    output start, ir_sel, len, tdi_data, TDO,
    input  TMS, TDI, busy, done, err, tdo_data, tap_state
  );

  modport slave (
    input  start, ir_sel, len, tdi_data, TDO,
    output TMS, TDI, busy, done, err, tdo_data, tap_state
  );
endinterface

// File: rtl/jtag_scan_sequencer.sv
// Walks the TAP from Run-Test/Idle through one IR or DR scan and back, driving TMS/TDI,
// capturing TDO and keeping a cycle-exact mirror of the TAP state.
module jtag_scan_sequencer #(
  parameter int unsigned MAX_LEN      = 32,
  parameter int unsigned LEN_W        = 6,
  parameter logic        TLR_EXIT_TMS = 1'b1
) (
  input logic TCK,
  input logic TRST,
  jtag_scan_sequencer_if.slave bus
);

  localparam int unsigned STEP_W = 2;
  localparam logic [LEN_W:0] LEN_MAX = (LEN_W+1)'(MAX_LEN);

  localparam logic [3:0] TLR    = 4'h0;
  localparam logic [3:0] RTI    = 4'h1;
  localparam logic [3:0] SEL_DR = 4'h2;
  localparam logic [3:0] CAP_DR = 4'h3;
  localparam logic [3:0] SH_DR  = 4'h4;
  localparam logic [3:0] EX1_DR = 4'h5;
  localparam logic [3:0] PAU_DR = 4'h6;
  localparam logic [3:0] EX2_DR = 4'h7;
  localparam logic [3:0] UPD_DR = 4'h8;
  localparam logic [3:0] SEL_IR = 4'h9;
  localparam logic [3:0] CAP_IR = 4'hA;
  localparam logic [3:0] SH_IR  = 4'hB;
  localparam logic [3:0] EX1_IR = 4'hC;
  localparam logic [3:0] PAU_IR = 4'hD;
  localparam logic [3:0] EX2_IR = 4'hE;
  localparam logic [3:0] UPD_IR = 4'hF;

  // State names the phase of the TMS value currently being driven.
  typedef enum logic [2:0] {
    INIT   = 3'd0,
    IDLE   = 3'd1,
    HDR    = 3'd2,
    SHIFT  = 3'd3,
    EXIT   = 3'd4,
    UPDATE = 3'd5
  } state_t;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
    logic [3:0] n;
    n = TLR;
    case (s)
      TLR:    n = (tms == TLR_EXIT_TMS) ? RTI : TLR;
      RTI:    n = tms ? SEL_DR : RTI;
      SEL_DR: n = tms ? SEL_IR : CAP_DR;
      CAP_DR: n = tms ? EX1_DR : SH_DR;
      SH_DR:  n = tms ? EX1_DR : SH_DR;
      EX1_DR: n = tms ? UPD_DR : PAU_DR;
      PAU_DR: n = tms ? EX2_DR : PAU_DR;
      EX2_DR: n = tms ? UPD_DR : SH_DR;
      UPD_DR: n = tms ? SEL_DR : RTI;
      SEL_IR: n = tms ? TLR    : CAP_IR;
      CAP_IR: n = tms ? EX1_IR : SH_IR;
      SH_IR:  n = tms ? EX1_IR : SH_IR;
      EX1_IR: n = tms ? UPD_IR : PAU_IR;
      PAU_IR: n = tms ? EX2_IR : PAU_IR;
      EX2_IR: n = tms ? UPD_IR : SH_IR;
      UPD_IR: n = tms ? SEL_DR : RTI;
      default: n = TLR;
    endcase
    return n;
  endfunction

  state_t              state_q, state_d;
  logic                tms_q, tms_d;
  logic                tdi_q, tdi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [MAX_LEN-1:0]  tdo_q, tdo_d;
  logic [3:0]          tap_q, tap_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                ir_q, ir_d;
  logic [MAX_LEN-1:0]  sreg_q, sreg_d;

  logic                len_ok;
  logic [STEP_W-1:0]   hdr_last;
  logic [LEN_W-1:0]    len_last;

  assign len_ok   = (bus.len != '0) && ({1'b0, bus.len} <= LEN_MAX);
  assign hdr_last = ir_q ? STEP_W'(3) : STEP_W'(2);
  assign len_last = len_q - LEN_W'(1);

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      state_q <= INIT;
      tms_q   <= TLR_EXIT_TMS;
      tdi_q   <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tdo_q   <= '0;
      tap_q   <= TLR;
      step_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ir_q    <= 1'b0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tdo_q   <= tdo_d;
      tap_q   <= tap_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ir_q    <= ir_d;
      sreg_q  <= sreg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tms_d   = tms_q;
    tdi_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    tdo_d   = tdo_q;
    tap_d   = tap_next(tap_q, tms_q);
    step_d  = step_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ir_d    = ir_q;
    sreg_d  = sreg_q;

    // tdo_data is cleared on accept, so OR-ing each captured bit into place is enough.
    if (tap_q == SH_DR || tap_q == SH_IR) begin
      tdo_d = tdo_q | (MAX_LEN'(bus.TDO) << cnt_q);
    end

    case (state_q)
      INIT: begin
        state_d = IDLE;
        tms_d   = 1'b0;
        busy_d  = 1'b0;
      end
      IDLE: begin
        tms_d = 1'b0;
        if (bus.start) begin
          if (len_ok) begin
            state_d = HDR;
            busy_d  = 1'b1;
            tms_d   = 1'b1;
            step_d  = '0;
            ir_d    = bus.ir_sel;
            len_d   = bus.len;
            sreg_d  = bus.tdi_data;
            tdo_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      HDR: begin
        // Header after the leading 1: IR adds a second 1 (SelDR>SelIR), then zeros.
        if (step_q == hdr_last) begin
          state_d = SHIFT;
          cnt_d   = '0;
          tms_d   = (len_q == LEN_W'(1));
          tdi_d   = sreg_q[0];
          sreg_d  = sreg_q >> 1;
        end else begin
          step_d = step_q + STEP_W'(1);
          tms_d  = ir_q && (step_q == '0);
        end
      end
      SHIFT: begin
        if (cnt_q == len_last) begin
          state_d = EXIT;
          tms_d   = 1'b1;
        end else begin
          cnt_d  = cnt_q + LEN_W'(1);
          tms_d  = ((cnt_q + LEN_W'(1)) == len_last);
          tdi_d  = sreg_q[0];
          sreg_d = sreg_q >> 1;
        end
      end
      EXIT: begin
        state_d = UPDATE;
        tms_d   = 1'b0;
      end
      UPDATE: begin
        state_d = IDLE;
        tms_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = INIT;
        tms_d   = TLR_EXIT_TMS;
        busy_d  = 1'b1;
      end
    endcase
  end

  assign bus.TMS       = tms_q;
  assign bus.TDI       = tdi_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.tdo_data  = tdo_q;
  assign bus.tap_state = tap_q;

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Scoreboard bench for jtag_scan_sequencer: directed scans against a behavioural TAP,
// with a monitor that checks every done/err pulse against queued expectations.
module tb_jtag_scan_sequencer;

  localparam int unsigned MAX_LEN = 32;
  localparam int unsigned LEN_W   = 6;

  logic tck  = 1'b0;
  logic trst = 1'b0;
  always #5 tck = ~tck;

  jtag_scan_sequencer_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus();

  jtag_scan_sequencer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .TLR_EXIT_TMS(1'b1)) dut (
    .TCK (tck),
    .TRST(trst),
    .bus (bus)
  );

  typedef struct {
    bit          is_err;
    logic [31:0] tdo;
    int          at;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [3:0]  m;
  bit          loop_mode = 1'b1;
  logic        tie_val   = 1'b0;
  int          tms_exp[10] = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 0};

  // Reference TAP; leaves Test-Logic-Reset on TMS=1.
  function automatic logic [3:0] tap_step(input logic [3:0] s, input logic tms);
    case (s)
      4'h0: return tms ? 4'h1 : 4'h0;
      4'h1: return tms ? 4'h2 : 4'h1;
      4'h2: return tms ? 4'h9 : 4'h3;
      4'h3: return tms ? 4'h5 : 4'h4;
      4'h4: return tms ? 4'h5 : 4'h4;
      4'h5: return tms ? 4'h8 : 4'h6;
      4'h6: return tms ? 4'h7 : 4'h6;
      4'h7: return tms ? 4'h8 : 4'h4;
      4'h8: return tms ? 4'h2 : 4'h1;
      4'h9: return tms ? 4'h0 : 4'hA;
      4'hA: return tms ? 4'hC : 4'hB;
      4'hB: return tms ? 4'hC : 4'hB;
      4'hC: return tms ? 4'hF : 4'hD;
      4'hD: return tms ? 4'hE : 4'hD;
      4'hE: return tms ? 4'hF : 4'hB;
      default: return tms ? 4'h2 : 4'h1;
    endcase
  endfunction

  always @(posedge tck or posedge trst) begin
    if (trst) m <= 4'h0;
    else      m <= tap_step(m, bus.TMS);
  end

  always @(posedge tck) cyc <= cyc + 1;

  assign bus.TDO = loop_mode ? (((m == 4'h4) || (m == 4'hB)) ? bus.TDI : 1'b0) : tie_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Mirror must track the TAP on every edge.
  always @(negedge tck) begin
    if (!trst) chk("tap_state_track", 32'(bus.tap_state), 32'(m));
  end

  // Scoreboard monitor: every done/err pulse pops one expectation.
  always @(negedge tck) begin
    exp_t e;
    if (!trst && (bus.done || bus.err)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got done=%0b err=%0b expected none (cycle %0d)",
                 bus.done, bus.err, cyc);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", 32'(bus.err), 32'(e.is_err));
        chk("pulse_cycle", 32'(cyc), 32'(e.at));
        chk("busy_at_pulse", 32'(bus.busy), 32'd0);
        if (!e.is_err) begin
          chk("tdo_data", bus.tdo_data, e.tdo);
          chk("tap_at_done", 32'(bus.tap_state), 32'd1);
        end
      end
    end
  end

  // Called at a negedge; the start is sampled on the following posedge.
  task automatic issue(input logic ir, input int l, input logic [31:0] d,
                       input logic [31:0] etdo, input bit eerr);
    exp_t e;
    bus.start    = 1'b1;
    bus.ir_sel   = ir;
    bus.len      = LEN_W'(l);
    bus.tdi_data = d;
    e.is_err = eerr;
    e.tdo    = etdo;
    e.at     = cyc + 1 + (eerr ? 0 : ((ir ? 4 : 3) + l + 2));
    sb.push_back(e);
    @(negedge tck);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge tck);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_reached", 32'(ok), 32'd1);
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      @(negedge tck);
    end
    chk("done_reached", 32'(ok), 32'd1);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.ir_sel   = 1'b0;
    bus.len      = '0;
    bus.tdi_data = '0;
    #1 trst = 1'b1;
    repeat (2) @(negedge tck);

    chk("rst_tms", 32'(bus.TMS), 32'd1);
    chk("rst_tdi", 32'(bus.TDI), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_tdo", bus.tdo_data, 32'd0);
    chk("rst_tap", 32'(bus.tap_state), 32'd0);

    // Release with a start present on the init edge; it must be ignored.
    trst       = 1'b0;
    bus.start  = 1'b1;
    bus.ir_sel = 1'b1;
    bus.len    = LEN_W'(4);
    @(negedge tck);
    bus.start = 1'b0;
    chk("init_tap", 32'(bus.tap_state), 32'd1);
    chk("init_tms", 32'(bus.TMS), 32'd0);
    chk("init_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge tck);
      chk("idle_tms", 32'(bus.TMS), 32'd0);
      chk("idle_busy", 32'(bus.busy), 32'd0);
    end

    // IR scan, len 4, looped TDO; TMS stream checked edge by edge.
    issue(1'b1, 4, 32'h0000_000A, 32'h0000_000A, 1'b0);
    for (int k = 0; k < 10; k++) begin
      chk("ir4_tms", 32'(bus.TMS), 32'(tms_exp[k]));
      @(negedge tck);
    end
    wait_idle();

    // Full-width DR scan with TDO tied high.
    loop_mode = 1'b0;
    tie_val   = 1'b1;
    issue(1'b0, 32, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0);
    wait_idle();
    loop_mode = 1'b1;
    tie_val   = 1'b0;
    repeat (3) @(negedge tck);
    chk("tdo_hold", bus.tdo_data, 32'hFFFF_FFFF);

    // Illegal lengths.
    issue(1'b0, 0, 32'h1234_5678, 32'h0, 1'b1);
    chk("rej0_busy", 32'(bus.busy), 32'd0);
    chk("rej0_tms", 32'(bus.TMS), 32'd0);
    chk("rej0_tap", 32'(bus.tap_state), 32'd1);
    chk("rej0_tdo", bus.tdo_data, 32'hFFFF_FFFF);
    issue(1'b1, 33, 32'h1234_5678, 32'h0, 1'b1);
    chk("rej33_busy", 32'(bus.busy), 32'd0);
    chk("rej33_tms", 32'(bus.TMS), 32'd0);
    chk("rej33_tap", 32'(bus.tap_state), 32'd1);
    @(negedge tck);
    chk("err_one_cycle", 32'(bus.err), 32'd0);

    // DR len 7 with starts pulsed while busy (bad and good lengths), all ignored.
    issue(1'b0, 7, 32'h0000_0055, 32'h0000_0055, 1'b0);
    bus.start = 1'b1;
    bus.len   = LEN_W'(0);
    @(negedge tck);
    bus.ir_sel = 1'b1;
    bus.len    = LEN_W'(5);
    @(negedge tck);
    bus.start = 1'b0;
    wait_idle();

    // Back-to-back: DR len 1, then IR len 2 on the edge after done.
    issue(1'b0, 1, 32'h0000_0001, 32'h0000_0001, 1'b0);
    wait_done();
    issue(1'b1, 2, 32'h0000_0002, 32'h0000_0002, 1'b0);
    wait_idle();

    // TRST while shifting DR bit 5.
    issue(1'b0, 8, 32'h0000_00F0, 32'h0, 1'b0);
    repeat (8) @(negedge tck);
    chk("pre_trst_tap", 32'(bus.tap_state), 32'h4);
    trst = 1'b1;
    sb.delete();
    #1;
    chk("trst_busy", 32'(bus.busy), 32'd1);
    chk("trst_tap", 32'(bus.tap_state), 32'd0);
    chk("trst_tms", 32'(bus.TMS), 32'd1);
    chk("trst_done", 32'(bus.done), 32'd0);
    chk("trst_tdo", bus.tdo_data, 32'd0);
    repeat (2) @(negedge tck);
    trst = 1'b0;
    @(negedge tck);
    chk("reinit_busy", 32'(bus.busy), 32'd0);
    chk("reinit_tap", 32'(bus.tap_state), 32'd1);
    issue(1'b1, 3, 32'h0000_0005, 32'h0000_0005, 1'b0);
    wait_idle();

    repeat (3) @(negedge tck);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
